// File: rtl/vga_scan.sv
// vga_scan: 640x480@60 VGA timing from a 4x pixel clock enable, reading the 128x96 VRAM upscaled 5x5.
// Optional VGA_TESTPAT_EN replaces VRAM colour with eight vertical colour bars.
module vga_scan #(
    parameter int CLK_DIV = 4,
    parameter int SCALE   = 5,
    parameter int IMG_W   = 128,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic        clk,
    input  logic        reset,
    output logic [13:0] address,
    input  logic        red_in,
    input  logic        green_in,
    input  logic        blue_in,
    output logic        vga_red,
    output logic        vga_green,
    output logic        vga_blue,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam logic [1:0]  PH_LAST  = 2'(CLK_DIV - 1);
    localparam logic [1:0]  PH_ADDR  = 2'd0;
    localparam logic [1:0]  PH_PIX   = 2'd2;
    localparam logic [2:0]  SUB_LAST = 3'(SCALE - 1);
    localparam logic [9:0]  H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0]  HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0]  VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [13:0] ADDR_MAX = 14'(((V_VIS - 1) / SCALE) * IMG_W + (H_VIS - 1) / SCALE);

    logic [1:0]  phase_q, phase_d;
    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [2:0]  hsub_q, hsub_d;
    logic [6:0]  hcol_q, hcol_d;
    logic [2:0]  vsub_q, vsub_d;
    logic [6:0]  vrow_q, vrow_d;
    logic [13:0] address_q, address_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;

    logic        pixel_tick;
    logic        line_wrap;
    logic        frame_wrap;
    logic        visible;
    logic [2:0]  pix_rgb;

    assign pixel_tick = (phase_q == PH_LAST);
    assign line_wrap  = pixel_tick && (hcount_q == H_LAST);
    assign frame_wrap = line_wrap && (vcount_q == V_LAST);
    assign visible    = (hcount_q < H_VIS_C) && (vcount_q < V_VIS_C);

`ifdef VGA_TESTPAT_EN
    logic unused_vram;
    assign unused_vram = red_in ^ green_in ^ blue_in;
    // Each bar is 16 VRAM columns = 80 screen pixels wide.
    assign pix_rgb = {hcol_q[6], hcol_q[5], hcol_q[4]};
`else
    assign pix_rgb = {red_in, green_in, blue_in};
`endif

    // Scan counters; hsub/vsub replace a divide-by-SCALE on hcount/vcount.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        phase_d  = pixel_tick ? 2'd0 : phase_q + 2'd1;
        hcount_d = hcount_q;
        hsub_d   = hsub_q;
        hcol_d   = hcol_q;
        vcount_d = vcount_q;
        vsub_d   = vsub_q;
        vrow_d   = vrow_q;

        if (line_wrap) begin
            hcount_d = '0;
            hsub_d   = '0;
            hcol_d   = '0;
        end else if (pixel_tick) begin
            hcount_d = hcount_q + 10'd1;
            if (hsub_q == SUB_LAST) begin
                hsub_d = '0;
                hcol_d = hcol_q + 7'd1;
            end else begin
                hsub_d = hsub_q + 3'd1;
            end
        end

        if (frame_wrap) begin
            vcount_d = '0;
            vsub_d   = '0;
            vrow_d   = '0;
        end else if (line_wrap) begin
            vcount_d = vcount_q + 10'd1;
            if (vsub_q == SUB_LAST) begin
                vsub_d = '0;
                vrow_d = vrow_q + 7'd1;
            end else begin
                vsub_d = vsub_q + 3'd1;
            end
        end
    end

    // Address leaves at phase 0, VRAM data is sampled at phase 2, so pins lag address by 2 clks.
    always_comb begin
        address_d     = address_q;
        rgb_d         = rgb_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = (phase_q == PH_ADDR) && (hcount_q == '0) && (vcount_q == '0);

        if ((phase_q == PH_ADDR) && visible) begin
            address_d = 14'(int'(vrow_q) * IMG_W + int'(hcol_q));
        end

        if (phase_q == PH_PIX) begin
            rgb_d   = visible ? pix_rgb : 3'b000;
            hsync_d = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
            vsync_d = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples the
    // pre-edge value of its peers, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q       <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsub_q        <= '0;
            hcol_q        <= '0;
            vsub_q        <= '0;
            vrow_q        <= '0;
            address_q     <= '0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsub_q        <= hsub_d;
            hcol_q        <= hcol_d;
            vsub_q        <= vsub_d;
            vrow_q        <= vrow_d;
            address_q     <= address_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign address     = address_q;
    assign vga_red     = rgb_q[2];
    assign vga_green   = rgb_q[1];
    assign vga_blue    = rgb_q[0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

    a_addr_range: assert property (@(posedge clk) disable iff (!reset) address_q <= ADDR_MAX);
    a_sub_range:  assert property (@(posedge clk) disable iff (!reset)
                                   (hsub_q <= SUB_LAST) && (vsub_q <= SUB_LAST));
    a_phase_wrap: assert property (@(posedge clk) disable iff (!reset) phase_q <= PH_LAST);

endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: directed vectors for vga_scan plus a short-frame instance for vertical timing.
module tb_vga_scan;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [13:0] addr_m, addr_s;
    logic        r_m, g_m, b_m, hs_m, vs_m, fs_m;
    logic        r_s, g_s, b_s, hs_s, vs_s, fs_s;
    logic [2:0]  vram_q = 3'b000, vram_s_q = 3'b000;
    logic        vram_by_addr = 1'b0;
    logic [2:0]  vram_val = 3'b101;

    vga_scan dut (
        .clk(clk), .reset(rst_n), .address(addr_m),
        .red_in(vram_q[2]), .green_in(vram_q[1]), .blue_in(vram_q[0]),
        .vga_red(r_m), .vga_green(g_m), .vga_blue(b_m),
        .hsync(hs_m), .vsync(vs_m), .frame_start(fs_m)
    );

    // Same timing with a 9-line frame (5 visible, fp 1, sync 2, bp 1).
    vga_scan #(.V_VIS(5), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_s (
        .clk(clk), .reset(rst_n), .address(addr_s),
        .red_in(vram_s_q[2]), .green_in(vram_s_q[1]), .blue_in(vram_s_q[0]),
        .vga_red(r_s), .vga_green(g_s), .vga_blue(b_s),
        .hsync(hs_s), .vsync(vs_s), .frame_start(fs_s)
    );

    // 1-clk-latency VRAM: either a fixed colour or the low address bits.
    always @(posedge clk) begin
        vram_q   <= vram_by_addr ? addr_m[2:0] : vram_val;
        vram_s_q <= vram_by_addr ? addr_s[2:0] : vram_val;
    end

    int edge_cnt = 0;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic goto(input int k);
        while (edge_cnt < k) @(negedge clk);
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Edge-time monitor: outputs may only move 3 clks, address 1 clk, after a pixel boundary.
    int       epoch = 0;
    int       phase_err = 0;
    int       addr_err = 0;
    int       hs_fall[$], hs_rise[$], vs_m_fall[$], vs_s_fall[$], vs_s_rise[$];
    int       fs_s_rise[$], fs_s_fall[$];
    logic [9:0]  out_prev = '0;
    logic [13:0] am_prev = '0, as_prev = '0;
    logic        hs_prev = 1'b1, vs_m_prev = 1'b1, vs_s_prev = 1'b1, fs_s_prev = 1'b0;

    always @(negedge clk) begin
        logic [9:0] outs;
        outs = {r_m, g_m, b_m, hs_m, vs_m, r_s, g_s, b_s, hs_s, vs_s};
        if (rst_n && edge_cnt > 0) begin
            if (outs !== out_prev && (edge_cnt % 4) != 3) phase_err++;
            if ((addr_m !== am_prev || addr_s !== as_prev) && (edge_cnt % 4) != 1) phase_err++;
            if (addr_m > 14'd12287) addr_err++;
            if (epoch == 0) begin
                if (hs_prev && !hs_m)     hs_fall.push_back(edge_cnt);
                if (!hs_prev && hs_m)     hs_rise.push_back(edge_cnt);
                if (vs_m_prev && !vs_m)   vs_m_fall.push_back(edge_cnt);
                if (vs_s_prev && !vs_s)   vs_s_fall.push_back(edge_cnt);
                if (!vs_s_prev && vs_s)   vs_s_rise.push_back(edge_cnt);
                if (!fs_s_prev && fs_s)   fs_s_rise.push_back(edge_cnt);
                if (fs_s_prev && !fs_s)   fs_s_fall.push_back(edge_cnt);
            end
        end
        out_prev  = outs;
        am_prev   = addr_m;
        as_prev   = addr_s;
        hs_prev   = hs_m;
        vs_m_prev = vs_m;
        vs_s_prev = vs_s;
        fs_s_prev = fs_s;
    end

    typedef struct {
        int         line;
        int         pix;
        logic       by_addr;
        logic [2:0] vram;
        logic [13:0] addr;
        logic [2:0] rgb;
        logic       hs;
        logic [2:0] s_rgb;
        logic       s_vis;
        logic       s_vs;
    } vec_t;

    vec_t vecs [19];

`ifdef VGA_TESTPAT_EN
    function automatic logic [2:0] bar(input int pix);
        return 3'(pix / 80);
    endfunction
`endif

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_cnt);
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] exp_m, exp_s;
        //          line pix  by   vram    addr      rgb    hs    s_rgb  s_vis s_vs
        vecs[0]  = '{0,   0,   1'b0, 3'b101, 14'd0,   3'b101, 1'b1, 3'b101, 1'b1, 1'b1};
        vecs[1]  = '{0,   4,   1'b0, 3'b011, 14'd0,   3'b011, 1'b1, 3'b011, 1'b1, 1'b1};
        vecs[2]  = '{0,   5,   1'b1, 3'b000, 14'd1,   3'b001, 1'b1, 3'b001, 1'b1, 1'b1};
        vecs[3]  = '{0,   9,   1'b1, 3'b000, 14'd1,   3'b001, 1'b1, 3'b001, 1'b1, 1'b1};
        vecs[4]  = '{0,   10,  1'b1, 3'b000, 14'd2,   3'b010, 1'b1, 3'b010, 1'b1, 1'b1};
        vecs[5]  = '{0,   639, 1'b1, 3'b000, 14'd127, 3'b111, 1'b1, 3'b111, 1'b1, 1'b1};
        vecs[6]  = '{0,   640, 1'b0, 3'b101, 14'd127, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1};
        vecs[7]  = '{0,   655, 1'b0, 3'b101, 14'd127, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1};
        vecs[8]  = '{0,   656, 1'b0, 3'b101, 14'd127, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1};
        vecs[9]  = '{0,   751, 1'b0, 3'b101, 14'd127, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1};
        vecs[10] = '{0,   752, 1'b0, 3'b101, 14'd127, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1};
        vecs[11] = '{0,   799, 1'b0, 3'b101, 14'd127, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1};
        vecs[12] = '{1,   0,   1'b1, 3'b000, 14'd0,   3'b000, 1'b1, 3'b000, 1'b1, 1'b1};
        vecs[13] = '{4,   637, 1'b1, 3'b000, 14'd127, 3'b111, 1'b1, 3'b111, 1'b1, 1'b1};
        vecs[14] = '{5,   0,   1'b1, 3'b000, 14'd128, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1};
        vecs[15] = '{5,   7,   1'b1, 3'b000, 14'd129, 3'b001, 1'b1, 3'b000, 1'b0, 1'b1};
        vecs[16] = '{7,   100, 1'b1, 3'b000, 14'd148, 3'b100, 1'b1, 3'b000, 1'b0, 1'b0};
        vecs[17] = '{9,   24,  1'b1, 3'b000, 14'd132, 3'b100, 1'b1, 3'b100, 1'b1, 1'b1};
        vecs[18] = '{10,  300, 1'b0, 3'b110, 14'd316, 3'b110, 1'b1, 3'b110, 1'b1, 1'b1};

        #1 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        check("reset address", addr_m, 0);
        check("reset rgb", {r_m, g_m, b_m}, 0);
        check("reset hsync", hs_m, 1);
        check("reset vsync", vs_m, 1);
        check("reset frame_start", fs_m, 0);
        check("reset frame_start short", fs_s, 0);
        #7 rst_n = 1'b1;

        goto(1);
        check("frame_start after release", fs_m, 1);
        check("frame_start short after release", fs_s, 1);
        check("address at (0,0)", addr_m, 0);
        goto(2);
        check("frame_start one clk", fs_m, 0);

        foreach (vecs[i]) begin
            vram_by_addr = vecs[i].by_addr;
            vram_val     = vecs[i].vram;
            goto(4 * (vecs[i].line * 800 + vecs[i].pix) + 3);
`ifdef VGA_TESTPAT_EN
            exp_m = (vecs[i].pix < 640) ? bar(vecs[i].pix) : 3'b000;
            exp_s = vecs[i].s_vis ? bar(vecs[i].pix) : 3'b000;
`else
            exp_m = vecs[i].rgb;
            exp_s = vecs[i].s_rgb;
`endif
            check($sformatf("v%0d address", i), addr_m, vecs[i].addr);
            check($sformatf("v%0d rgb", i), {r_m, g_m, b_m}, exp_m);
            check($sformatf("v%0d hsync", i), hs_m, vecs[i].hs);
            check($sformatf("v%0d vsync", i), vs_m, 1);
            check($sformatf("v%0d short rgb", i), {r_s, g_s, b_s}, exp_s);
            check($sformatf("v%0d short hsync", i), hs_s, vecs[i].hs);
            check($sformatf("v%0d short vsync", i), vs_s, vecs[i].s_vs);
        end

        // Mid-frame reset at line 10, pixel 300, held for 35 time units.
        epoch = 1;
        #2 rst_n = 1'b0;
        #1;
        check("midreset address", addr_m, 0);
        check("midreset rgb", {r_m, g_m, b_m}, 0);
        check("midreset hsync", hs_m, 1);
        check("midreset vsync", vs_m, 1);
        check("midreset frame_start", fs_m, 0);
        check("midreset short address", addr_s, 0);
        #34 rst_n = 1'b1;

        goto(1);
        check("restart frame_start", fs_m, 1);
        goto(23);
        check("restart address at (0,5)", addr_m, 1);
        goto(2627);
        check("restart hsync low", hs_m, 0);
        goto(3011);
        check("restart hsync high", hs_m, 1);

        check("hsync first fall", qget(hs_fall, 0), 2627);
        check("hsync low width", qget(hs_rise, 0) - qget(hs_fall, 0), 384);
        check("hsync period", qget(hs_fall, 1) - qget(hs_fall, 0), 3200);
        check("main vsync stays high", vs_m_fall.size(), 0);
        check("short vsync first fall", qget(vs_s_fall, 0), 19203);
        check("short vsync low width", qget(vs_s_rise, 0) - qget(vs_s_fall, 0), 6400);
        check("short frame_start first", qget(fs_s_rise, 0), 1);
        check("short frame_start period", qget(fs_s_rise, 1) - qget(fs_s_rise, 0), 28800);
        check("short frame_start width", qget(fs_s_fall, 1) - qget(fs_s_rise, 1), 1);
        check("output change phase", phase_err, 0);
        check("address bound", addr_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
